mul_seq_ctrl: RTL and testbench
===============================

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter N, default 32: operand width in bits; legal values 4..64.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a multiply; sampled on the rising edge of clk.
REQ-005 a  input  N  multiplicand; sampled only on the edge that accepts start.
REQ-006 b  input  N  multiplier; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while the state is RUN.
REQ-008 done  output  1  single-cycle pulse; high while the state is DONE.
REQ-009 y  output  2N  product; valid when done is high, held until the next DONE.

Function
REQ-010 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 Accept rule: start high at an edge with the state IDLE or DONE SHALL capture a and b, clear the accumulator and counter, and enter RUN.
REQ-012 start while in RUN SHALL be ignored, with no effect on operands, counter or y.
REQ-013 RUN SHALL perform one radix-2 shift-add step per cycle for exactly N cycles.
- Step: if multiplier LSB = 1, add multiplicand to the upper N bits of the accumulator.
- The add produces an N+1-bit sum; the carry SHALL be kept.
- The accumulator then shifts right by 1, and the multiplier shifts right by 1.
REQ-014 The counter SHALL be a ceil(log2(N+1))-bit counter counting 0..N-1; on the edge where it reaches N-1 and the last step completes, the state SHALL go to DONE.
REQ-015 Latency: with start accepted at edge k, done SHALL be high in the cycle following edge k+N and low otherwise.
REQ-016 y SHALL load the full 2N-bit accumulator only on entry to DONE. No intermediate value SHALL appear on y.
REQ-017 DONE SHALL last exactly one cycle. From DONE, the next state SHALL be RUN if start is high, else IDLE.
REQ-018 Back-to-back operation: start held high continuously SHALL produce one product every N+1 cycles.
REQ-019 Zero operands SHALL take the full N cycles; there is no early exit.
REQ-020 busy and done SHALL never be high in the same cycle.

Reset
REQ-021 rst_n low SHALL immediately force the following, regardless of the current state, including mid-RUN:
- state = IDLE
- busy = 0, done = 0
- y = 0, counter = 0
- accumulator and operand registers = 0
REQ-022 The first start after rst_n deasserts SHALL follow REQ-011 normally. An aborted operation SHALL produce no done.

Configuration
REQ-023 Macro MUL_SEQ_CTRL_SIGNED_EN defined:
- An extra input sgn (1 bit) SHALL be added; it is sampled with a and b.
- When sgn = 1, a and b SHALL be treated as two's complement.
- The magnitudes SHALL be multiplied per REQ-013.
- If the operand signs differ, the result SHALL be negated in 2N bits when loaded into y.
- Latency SHALL be unchanged.
REQ-024 Macro MUL_SEQ_CTRL_SIGNED_EN undefined: the sgn port SHALL be absent and all operands SHALL be unsigned.

Structure
REQ-025 Shared package mul_seq_pkg SHALL hold:
- the state encoding (IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10);
- the default width constant (32);
- the counter-width function.
REQ-026 One sub-module, mul_seq_dp, SHALL hold the accumulator, operand registers and the N-bit adder.
- The adder SHALL reuse the team's N-bit adder block.
- mul_seq_ctrl SHALL hold only the FSM, the counter and the output registers.

Verification
REQ-027 N=32, a=3, b=5, start pulsed at edge k -> done high after edge k+32, y = 15, busy high for exactly 32 cycles.
REQ-028 a=0xFFFFFFFF, b=0xFFFFFFFF -> y = 0xFFFFFFFE00000001; carry propagation is verified.
REQ-029 start again with a=7, b=9 at edge k+10 during RUN -> ignored; the first result (15) arrives on time and no second done follows.
REQ-030 rst_n low at edge k+16 mid-RUN -> busy, done and y are 0 immediately; no done appears within 40 cycles.
REQ-031 start held high, operand pairs (2,3) then (4,5) -> done pulses 33 cycles apart, y = 6 then y = 20.
REQ-032 With MUL_SEQ_CTRL_SIGNED_EN, sgn=1, a=-3 (0xFFFFFFFD), b=5 -> y = 0xFFFFFFFFFFFFFFF1; with sgn=0 the same inputs give y = 0x4FFFFFFF1.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// default operand width and counter sizing.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int MUL_N_DEFAULT = 32;

    // Enough bits to hold the step index 0..n-1 with headroom up to n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/add_n.sv
// Generic W-bit adder with the carry returned as the MSB of a W+1-bit sum.
module add_n #(
    parameter int W = 32
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W:0]   s
);

    assign s = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/mul_seq_dp.sv
// Shift-add datapath: operand registers, 2N-bit accumulator and the N-bit adder.
// Optional signed support is built when MUL_SEQ_CTRL_SIGNED_EN is defined.
module mul_seq_dp
    import mul_seq_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef MUL_SEQ_CTRL_SIGNED_EN
    input  logic           sgn,
`endif
    output logic [2*N-1:0] prod_next
);

    logic [N-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] acc_step;
    logic [N-1:0]   addend;
    logic [N:0]     sum;
    logic [N-1:0]   a_mag, b_mag;
    logic           acc_lsb_unused;

    // The accumulator LSB is shifted out every step and never needed again.
    assign acc_lsb_unused = acc_q[0];

`ifdef MUL_SEQ_CTRL_SIGNED_EN
    logic neg_q, neg_d;

    // Multiply magnitudes; the most negative value maps to 2^(N-1), which still fits.
    assign a_mag = (sgn && a[N-1]) ? (~a + 1'b1) : a;
    assign b_mag = (sgn && b[N-1]) ? (~b + 1'b1) : b;
    assign prod_next = neg_q ? (~acc_step + 1'b1) : acc_step;
`else
    assign a_mag     = a;
    assign b_mag     = b;
    assign prod_next = acc_step;
`endif

    assign addend = mplier_q[0] ? mcand_q : '0;

    add_n #(.W(N)) u_add (
        .x (acc_q[2*N-1:N]),
        .y (addend),
        .s (sum)
    );

    // Carry lands in the MSB as the accumulator shifts right.
    assign acc_step = {sum, acc_q[N-1:1]};

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (load) begin
            mcand_d  = a_mag;
            mplier_d = b_mag;
            acc_d    = '0;
        end else if (step) begin
            acc_d    = acc_step;
            mplier_d = mplier_q >> 1;
        end
    end

`ifdef MUL_SEQ_CTRL_SIGNED_EN
    always_comb begin
        neg_d = neg_q;
        if (load) begin
            neg_d = sgn & (a[N-1] ^ b[N-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential N-cycle shift-add multiplier: FSM, step counter and output registers.
// Define MUL_SEQ_CTRL_SIGNED_EN to add the sgn input for two's-complement operands.
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int N = MUL_N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
`ifdef MUL_SEQ_CTRL_SIGNED_EN
    input  logic           sgn,
`endif
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] y
);

    localparam int CW = cnt_width(N);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2*N-1:0] y_q, y_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load, step, last_step;
    logic [2*N-1:0] prod_next;

    mul_seq_dp #(.N(N)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .a         (a),
        .b         (b),
`ifdef MUL_SEQ_CTRL_SIGNED_EN
        .sgn       (sgn),
`endif
        .prod_next (prod_next)
    );

    assign last_step = (state_q == ST_RUN) && (cnt_q == CW'(N - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last_step) begin
                    // y only ever sees the finished product.
                    y_d     = prod_next;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl at N=32.
// Signed cases are exercised when MUL_SEQ_CTRL_SIGNED_EN is defined.
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a, b;
`ifdef MUL_SEQ_CTRL_SIGNED_EN
    logic        sgn;
`endif
    logic        busy, done;
    logic [63:0] y;

    int checks = 0;
    int errors = 0;

    mul_seq_ctrl #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
`ifdef MUL_SEQ_CTRL_SIGNED_EN
        .sgn   (sgn),
`endif
        .busy  (busy),
        .done  (done),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the accepting edge (c=0).
    task automatic pulse(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
`ifdef MUL_SEQ_CTRL_SIGNED_EN
        sgn   = ts;
`else
        if (ts) $display("note: sgn ignored in unsigned build");
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        $display("start accepted a=%h b=%h", ta, tb_v);
    endtask

    // Samples once per falling edge; c counts rising edges after the accept edge.
    task automatic observe(input int ncyc, input int inj_at, input int drop_at,
                           output int busy_cnt, output int done_cnt,
                           output int d1, output int d2, output int both_cnt,
                           output int y_glitch, output logic [63:0] y1,
                           output logic [63:0] y2);
        logic [63:0] y_prev;
        y_prev = y;
        busy_cnt = 0; done_cnt = 0; d1 = -1; d2 = -1;
        both_cnt = 0; y_glitch = 0; y1 = '0; y2 = '0;
        for (int c = 0; c < ncyc; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cnt == 1) begin d1 = c; y1 = y; end
                else if (done_cnt == 2) begin d2 = c; y2 = y; end
            end
            if (busy && done) both_cnt++;
            if (!done && (y !== y_prev)) y_glitch++;
            y_prev = y;
            if (c == inj_at - 1) begin start = 1'b1; a = 32'd7; b = 32'd9; end
            if (c == inj_at) start = 1'b0;
            if (c == drop_at) start = 1'b0;
            @(negedge clk);
        end
    endtask

    int bc, dc, d1, d2, bo, yg;
    logic [63:0] y1, y2;

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef MUL_SEQ_CTRL_SIGNED_EN
        sgn   = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_y", y, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // 3*5 with a second start injected at edge k+10 that must be ignored
        pulse(32'd3, 32'd5, 1'b0);
        observe(80, 10, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t1 done_at=%0d y=%h busy_cycles=%0d dones=%0d", d1, y1, bc, dc);
        chk("t1_done_latency", 64'(d1), 64'd32);
        chk("t1_y", y1, 64'd15);
        chk("t1_busy_cycles", 64'(bc), 64'd32);
        chk("t1_done_count", 64'(dc), 64'd1);
        chk("t1_busy_and_done", 64'(bo), 64'd0);
        chk("t1_y_intermediate", 64'(yg), 64'd0);
        chk("t1_y_held", y, 64'd15);

        // Reset asserted mid-run
        pulse(32'd9, 32'd9, 1'b0);
        repeat (15) @(negedge clk);
        chk("t4_busy_before_reset", 64'(busy), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("t4 reset mid-run busy=%b done=%b y=%h", busy, done, y);
        chk("t4_busy_reset", 64'(busy), 64'd0);
        chk("t4_done_reset", 64'(done), 64'd0);
        chk("t4_y_reset", y, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        observe(40, -1, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t4 after reset dones=%0d busy_cycles=%0d", dc, bc);
        chk("t4_no_done", 64'(dc), 64'd0);
        chk("t4_no_busy", 64'(bc), 64'd0);

        // Full carry propagation
        pulse(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        observe(40, -1, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t2 done_at=%0d y=%h", d1, y1);
        chk("t2_done_latency", 64'(d1), 64'd32);
        chk("t2_y", y1, 64'hFFFF_FFFE_0000_0001);
        chk("t2_y_held", y, 64'hFFFF_FFFE_0000_0001);

        // Zero operands still take the full N cycles
        pulse(32'd0, 32'd0, 1'b0);
        observe(40, -1, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t3 done_at=%0d y=%h busy_cycles=%0d", d1, y1, bc);
        chk("t3_done_latency", 64'(d1), 64'd32);
        chk("t3_y", y1, 64'd0);
        chk("t3_busy_cycles", 64'(bc), 64'd32);

        // Back-to-back with start held high: (2,3) then (4,5)
        start = 1'b1;
        a = 32'd2;
        b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        a = 32'd4;
        b = 32'd5;
        observe(80, -1, 33, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t5 done_at=%0d,%0d y=%h,%h", d1, d2, y1, y2);
        chk("t5_first_done", 64'(d1), 64'd32);
        chk("t5_done_spacing", 64'(d2 - d1), 64'd33);
        chk("t5_y_first", y1, 64'd6);
        chk("t5_y_second", y2, 64'd20);
        chk("t5_done_count", 64'(dc), 64'd2);
        chk("t5_busy_and_done", 64'(bo), 64'd0);

`ifdef MUL_SEQ_CTRL_SIGNED_EN
        pulse(32'hFFFF_FFFD, 32'd5, 1'b1);
        observe(40, -1, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t6 signed done_at=%0d y=%h", d1, y1);
        chk("t6_signed_latency", 64'(d1), 64'd32);
        chk("t6_signed_y", y1, 64'hFFFF_FFFF_FFFF_FFF1);
        pulse(32'hFFFF_FFFD, 32'd5, 1'b0);
        observe(40, -1, -1, bc, dc, d1, d2, bo, yg, y1, y2);
        $display("t7 unsigned-mode done_at=%0d y=%h", d1, y1);
        chk("t7_unsigned_y", y1, 64'h0000_0004_FFFF_FFF1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
